pwm_ramp_controller: RTL

Sequences a pwm_generator instance so duty changes are gradual (soft-start and soft-stop).
- Accepts a target duty, step interval and PWM period over a valid/ready config handshake.
- Drives the generator's enable, frequency, duty_inc and duty_dec inputs.
- Keeps a shadow copy of the generator's internal duty register.
- Sits between the register/config interface and the generator; shares clk and reset with it.

---
 rtl/pwm_ctrl_pkg.sv | 17 +
 rtl/pwm_ramp_controller_if.sv | 26 ++
 rtl/pwm_step_timer.sv | 37 +++
 rtl/pwm_ramp_controller.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM ramp controller.
// PWM_RAMP_FAULT_EN enables the FAULT state in the controller.
package pwm_ctrl_pkg;

   localparam int unsigned DEF_DUTY_W   = 8;
   localparam int unsigned DEF_FREQ_W   = 16;
   localparam int unsigned DEF_STEP_W   = 16;
   localparam int unsigned STEP_DIV_MIN = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RAMP  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_FAULT = 2'd3
   } ctrl_state_e;

endpackage

// File: rtl/pwm_ramp_controller_if.sv
// Config valid/ready handshake between the register block and the ramp controller.
interface pwm_ramp_controller_if
   import pwm_ctrl_pkg::*;
#(
   parameter int unsigned DUTY_W = DEF_DUTY_W,
   parameter int unsigned FREQ_W = DEF_FREQ_W,
   parameter int unsigned STEP_W = DEF_STEP_W
) ();

   logic              cfg_valid;
   logic              cfg_ready;
   logic [DUTY_W-1:0] cfg_target;
   logic [STEP_W-1:0] cfg_step_div;
   logic [FREQ_W-1:0] cfg_frequency;

   modport master (
      output cfg_valid, cfg_target, cfg_step_div, cfg_frequency,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_target, cfg_step_div, cfg_frequency,
      output cfg_ready
   );

endinterface

// File: rtl/pwm_step_timer.sv
// Step-interval counter: ticks every step_div enabled cycles, clears on tick or clear.
module pwm_step_timer
   import pwm_ctrl_pkg::*;
#(
   parameter int unsigned STEP_W = DEF_STEP_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              enable,
   input  logic [STEP_W-1:0] step_div,
   output logic              tick_c
);

   logic [STEP_W-1:0] cnt_q, cnt_d;

   // step_div is never stored below STEP_DIV_MIN, so the subtraction cannot wrap
   assign tick_c = enable && (cnt_q == (step_div - STEP_W'(STEP_DIV_MIN)));

   always_comb begin
      cnt_d = cnt_q;
      if (clear || tick_c) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_q + STEP_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pwm_ramp_controller.sv
// Soft-start/soft-stop sequencer for a pwm_generator; keeps a shadow of its duty register.
// Optional macro PWM_RAMP_FAULT_EN adds fault/fault_clr/fault_latched and a FAULT state.
module pwm_ramp_controller
   import pwm_ctrl_pkg::*;
#(
   parameter int unsigned DUTY_W = DEF_DUTY_W,
   parameter int unsigned FREQ_W = DEF_FREQ_W,
   parameter int unsigned STEP_W = DEF_STEP_W
) (
   input  logic                  clk,
   input  logic                  reset,
   pwm_ramp_controller_if.slave  cfg,
   input  logic                  run,
   input  logic                  abort,
   output logic                  pwm_enable,
   output logic [FREQ_W-1:0]     pwm_frequency,
   output logic                  duty_inc,
   output logic                  duty_dec,
   output logic [DUTY_W-1:0]     duty_mirror,
   output logic                  busy,
   output logic                  done
`ifdef PWM_RAMP_FAULT_EN
   ,
   input  logic                  fault,
   input  logic                  fault_clr,
   output logic                  fault_latched
`endif
);

   ctrl_state_e       state_q, state_d;
   logic [DUTY_W-1:0] target_q, target_d;
   logic [STEP_W-1:0] step_div_q, step_div_d;
   logic [FREQ_W-1:0] freq_q, freq_d;
   logic [DUTY_W-1:0] mirror_q, mirror_d;
   logic              inc_q, inc_d, dec_q, dec_d, done_q, done_d;
   logic              en_q, en_d, busy_q, busy_d, ready_q, ready_d;
   logic              flt_q, flt_d;
   logic              fault_c, fault_clr_c, accept_c, tick_c;

`ifdef PWM_RAMP_FAULT_EN
   assign fault_c       = fault;
   assign fault_clr_c   = fault_clr;
   assign fault_latched = flt_q;
`else
   assign fault_c     = 1'b0;
   assign fault_clr_c = 1'b0;
`endif

   assign accept_c = cfg.cfg_valid && ready_q;

   pwm_step_timer #(.STEP_W(STEP_W)) u_step_timer (
      .clk      (clk),
      .reset    (reset),
      .clear    (accept_c),
      .enable   (run && (state_q == ST_RAMP)),
      .step_div (step_div_q),
      .tick_c   (tick_c)
   );

   // Next-state and registered-output logic; fault outranks accept, abort and step
   always_comb begin
      state_d    = state_q;
      target_d   = target_q;
      step_div_d = step_div_q;
      freq_d     = freq_q;
      mirror_d   = mirror_q;
      flt_d      = flt_q;
      inc_d      = 1'b0;
      dec_d      = 1'b0;
      done_d     = 1'b0;

      if (fault_c) begin
         state_d = ST_FAULT;
         flt_d   = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE, ST_HOLD: begin
               if (accept_c) begin
                  target_d   = cfg.cfg_target;
                  step_div_d = (cfg.cfg_step_div == '0) ? STEP_W'(STEP_DIV_MIN) : cfg.cfg_step_div;
                  freq_d     = cfg.cfg_frequency;
                  state_d    = ST_RAMP;
               end
            end
            ST_RAMP: begin
               if (abort) begin
                  state_d = ST_HOLD;
               end else if (mirror_q == target_q) begin
                  state_d = ST_HOLD;
                  done_d  = 1'b1;
               end else if (tick_c) begin
                  if (mirror_q < target_q) begin
                     inc_d    = 1'b1;
                     mirror_d = mirror_q + DUTY_W'(1);
                  end else begin
                     dec_d    = 1'b1;
                     mirror_d = mirror_q - DUTY_W'(1);
                  end
               end
            end
            ST_FAULT: begin
               if (fault_clr_c) begin
                  state_d = ST_IDLE;
                  flt_d   = 1'b0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      en_d    = run && !fault_c && ((state_q == ST_RAMP) || (state_q == ST_HOLD));
      busy_d  = (state_d == ST_RAMP);
      ready_d = (state_d == ST_IDLE) || (state_d == ST_HOLD);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         target_q   <= '0;
         step_div_q <= STEP_W'(STEP_DIV_MIN);
         freq_q     <= '0;
         mirror_q   <= '0;
         inc_q      <= 1'b0;
         dec_q      <= 1'b0;
         done_q     <= 1'b0;
         en_q       <= 1'b0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b1;
         flt_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         target_q   <= target_d;
         step_div_q <= step_div_d;
         freq_q     <= freq_d;
         mirror_q   <= mirror_d;
         inc_q      <= inc_d;
         dec_q      <= dec_d;
         done_q     <= done_d;
         en_q       <= en_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
         flt_q      <= flt_d;
      end
   end

   assign cfg.cfg_ready = ready_q;
   assign pwm_enable    = en_q;
   assign pwm_frequency = freq_q;
   assign duty_inc      = inc_q;
   assign duty_dec      = dec_q;
   assign duty_mirror   = mirror_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule
